// File: rtl/cache_pmem_arbiter_if.sv
// Cacheline physical-memory port bundle.
// One instance per link: icache->arbiter, dcache->arbiter, arbiter->memory.
//   read/write : request strobes, held by the requester until resp
//   address    : line address
//   wdata      : writeback line (meaningful only with write)
//   rdata      : fill line, valid alongside resp
//   resp       : one-cycle completion pulse
// The icache link never writes; its write/wdata are tied low by the client.
interface cache_pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] rdata;
  logic                  resp;

  modport master (output read, write, address, wdata, input  rdata, resp);
  modport slave  (input  read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/cache_pmem_arbiter.sv
// Round-robin arbiter merging icache fills and dcache fills/writebacks onto
// a single cacheline memory port, one transaction in flight at a time.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_pmem   : icache link (slave side; read-only client)
//   d_pmem   : dcache link (slave side; read and write)
//   mem      : memory link (master side)
// Memory-side request signals come only from registers latched at grant,
// so client inputs never reach mem_* combinationally.
module cache_pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_pmem_arbiter_if.slave  i_pmem,
  cache_pmem_arbiter_if.slave  d_pmem,
  cache_pmem_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} client_t;

  state_t                state;
  client_t               last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  read_q;
  logic                  write_q;

  logic i_req, d_req, pick_d;

  assign i_req  = i_pmem.read;
  assign d_req  = d_pmem.read | d_pmem.write;
  // On a tie the client that did not win last time is chosen.
  assign pick_d = d_req & (~i_req | (last_grant == GNT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= SERVE_D;
            last_grant <= GNT_D;
            addr_q     <= d_pmem.address;
            // read+write together is illegal; treat it as a writeback
            write_q    <= d_pmem.write;
            read_q     <= ~d_pmem.write;
            if (d_pmem.write) wdata_q <= d_pmem.wdata;
          end else if (i_req) begin
            state      <= SERVE_I;
            last_grant <= GNT_I;
            addr_q     <= i_pmem.address;
            read_q     <= 1'b1;
            write_q    <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Requests are held until the memory completes; going back through
          // IDLE gives the client a cycle to drop its request before re-arbitration.
          if (mem.resp) begin
            state   <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.read    = read_q;
  assign mem.write   = write_q;
  assign mem.address = addr_q;
  assign mem.wdata   = wdata_q;

  // Fill data goes to both clients; only the resp pulse names the owner.
  assign i_pmem.rdata = mem.rdata;
  assign d_pmem.rdata = mem.rdata;
  assign i_pmem.resp  = (state == SERVE_I) & mem.resp;
  assign d_pmem.resp  = (state == SERVE_D) & mem.resp;

  // The icache link carries no writes.
  logic unused_i_write;
  assign unused_i_write = ^{i_pmem.write, i_pmem.wdata};
endmodule
